legv8_instr_encoder: RTL and testbench
======================================

Name: legv8_instr_encoder

Overview:
- Inverse of the LEGv8 main decoder: takes symbolic instruction fields (op, registers, immediate) and emits 32-bit LEGv8 machine words.
- Buffers encoded words in a small FIFO and streams them to the instruction-memory write port, with an auto-incrementing word address.
- Used by the bench and boot loader to build programs for the single-cycle/pipelined processor without hand-assembled hex.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, >=2)
- ADDR_W, 6, width of instruction-memory word address
- BASE_ADDR, 0, first word address after reset or clear

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush: empties FIFO, sets address to BASE_ADDR
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_op  in  3  op_t: LDUR, STUR, CBZ, ADD, SUB, AND, ORR
- in_rd  in  5  Rd/Rt
- in_rn  in  5  Rn
- in_rm  in  5  Rm
- in_imm  in  19  signed immediate: DT_address or COND_BR_address
- out_valid  out  1  encoded word available
- out_ready  in  1  memory accepts word
- out_instr  out  32  encoded instruction
- out_addr  out  ADDR_W  word address for out_instr
- err  out  1  one-cycle pulse: last accepted bundle was illegal

Behaviour:
- Reset (reset=0, async): FIFO empty, address=BASE_ADDR, out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0, in_ready=1 after release.
- Handshakes: input accepted when in_valid&&in_ready; output transfer when out_valid&&out_ready. in_valid/in_op/... held by source until accepted; out_instr/out_addr stable while out_valid&&!out_ready.
- in_ready = !full. No bypass: a pop in the same cycle does not free space for a push that cycle.
- Encoding, computed combinationally, pushed on acceptance:
  - R-type (ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000): {opc[10:0], rm, 6'b0, rn, rd}
  - D-type (LDUR 11111000010, STUR 11111000000): {opc, imm[8:0], 2'b00, rn, rd}
  - CB (CBZ 10110100): {8'b10110100, imm[18:0], rd}
- Illegal bundles: undefined in_op encoding, or D-type imm outside -256..255.
  - Still accepted (in_ready honoured), not pushed.
  - err=1 for exactly the cycle after acceptance; address does not advance.
- Latency: a word accepted into an empty FIFO gives out_valid=1 on the next cycle.
- out_addr = address of FIFO head. Address is captured per entry at push; the push counter increments by 1 per legal push and wraps modulo 2^ADDR_W silently.
- Simultaneous push and pop while neither full nor empty: both occur, count unchanged.
- clear has priority over push/pop that cycle; an in-flight accepted bundle is discarded; err is cleared.
- Reset mid-stream drops all contents; no partial word is ever presented.

Decomposition:
- legv8_pkg holds:
  - op_t enum (3 bits)
  - opcode constants OPC_LDUR, OPC_STUR, OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR (11 bits) and OPC_CBZ (8 bits)
  - DT_MIN=-256, DT_MAX=255
- These constants are shared with maindec tests.
- One sub-module: instr_fifo (synchronous FIFO, width 32+ADDR_W, DEPTH, flush input).

Test Plan:
- ADD rd=1 rn=2 rm=3, out_ready=1 -> out_instr=0x8B030041, out_addr=0, out_valid one cycle after accept.
- LDUR rd=5 rn=6 imm=8 then CBZ rd=7 imm=-2 -> 0xF84080C5 @addr0, 0xB4FFFFC7 @addr1, in order.
- STUR imm=256 -> accepted, err pulse 1 cycle, no output, next legal word still at addr0.
- out_ready=0, push 5 legal ORRs -> in_ready=0 after 4th; release out_ready -> addresses 0,1,2,3 then 4th... 5th accepted once space is free, address 4.
- Assert reset=0 asynchronously with 3 entries queued -> out_valid=0, out_addr=BASE_ADDR immediately; after release the first new word is at addr 0.
- clear asserted with simultaneous push and pop -> FIFO empty next cycle, push discarded, address=BASE_ADDR.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 encoding definitions: op enumeration, opcode fields, D-type offset range,
// and the field-to-word encode function used by the encoder (and maindec tests).
package legv8_pkg;

  typedef enum logic [2:0] {
    OpLdur = 3'd0,
    OpStur = 3'd1,
    OpCbz  = 3'd2,
    OpAdd  = 3'd3,
    OpSub  = 3'd4,
    OpAnd  = 3'd5,
    OpOrr  = 3'd6
  } op_t;

  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

  localparam int DT_MIN = -256;
  localparam int DT_MAX = 255;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  function automatic enc_t encode(op_t op, logic [4:0] rd, logic [4:0] rn, logic [4:0] rm,
                                  logic [18:0] imm);
    enc_t e;
    int   simm;
    e.legal = 1'b1;
    e.word  = '0;
    simm    = int'($signed(imm));
    case (op)
      OpLdur: begin
        e.word  = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
        e.legal = (simm >= DT_MIN) && (simm <= DT_MAX);
      end
      OpStur: begin
        e.word  = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
        e.legal = (simm >= DT_MIN) && (simm <= DT_MAX);
      end
      OpCbz:   e.word = {OPC_CBZ, imm, rd};
      OpAdd:   e.word = {OPC_ADD, rm, 6'b0, rn, rd};
      OpSub:   e.word = {OPC_SUB, rm, 6'b0, rn, rd};
      OpAnd:   e.word = {OPC_AND, rm, 6'b0, rn, rd};
      OpOrr:   e.word = {OPC_ORR, rm, 6'b0, rn, rd};
      default: e.legal = 1'b0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/legv8_instr_encoder_if.sv
// Field-bundle input handshake and instruction-memory write stream of the encoder.
interface legv8_instr_encoder_if #(
  parameter int unsigned ADDR_W = 6
);
  import legv8_pkg::*;

  logic              in_valid;
  logic              in_ready;
  op_t               in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rn;
  logic [4:0]        in_rm;
  logic [18:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              err;

  modport master (
    output in_valid, in_op, in_rd, in_rn, in_rm, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rn, in_rm, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, err
  );

endinterface

// File: rtl/instr_fifo.sv
// Synchronous FIFO with a synchronous flush; head entry is read combinationally.
module instr_fifo #(
  parameter int unsigned WIDTH = 38,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic             push_en, pop_en;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign push_en = push && !full && !flush;
  assign pop_en  = pop && !empty && !flush;
  assign rdata   = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/legv8_instr_encoder.sv
// Encodes symbolic LEGv8 field bundles into machine words and streams them, with
// auto-incrementing word addresses, to the instruction-memory write port.
module legv8_instr_encoder
  import legv8_pkg::*;
#(
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       ADDR_W    = 6,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic                  clk,
  input logic                  reset,
  input logic                  clear,
  legv8_instr_encoder_if.slave bus
);
  logic              full, empty, accept, push, pop;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31+ADDR_W:0] head;
  enc_t              enc;

  assign enc    = encode(bus.in_op, bus.in_rd, bus.in_rn, bus.in_rm, bus.in_imm);
  assign accept = bus.in_valid && !full;
  assign push   = accept && enc.legal && !clear;
  assign pop    = bus.out_ready && !empty && !clear;

  instr_fifo #(
    .WIDTH(32 + ADDR_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .flush(clear),
    .push (push),
    .pop  (pop),
    .wdata({enc.word, addr_q}),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

  // Illegal bundles are consumed without advancing the address; err flags them next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= BASE_ADDR;
      err_q  <= 1'b0;
    end else if (clear) begin
      addr_q <= BASE_ADDR;
      err_q  <= 1'b0;
    end else begin
      err_q <= accept && !enc.legal;
      if (push) addr_q <= addr_q + 1'b1;
    end
  end

  always_comb begin
    bus.in_ready  = !full;
    bus.out_valid = !empty;
    bus.err       = err_q;
    bus.out_instr = empty ? 32'd0 : head[31+ADDR_W:ADDR_W];
    bus.out_addr  = empty ? BASE_ADDR : head[ADDR_W-1:0];
  end

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Directed bench: expected words are queued at issue, a monitor checks each transfer.
module tb_legv8_instr_encoder;
  import legv8_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [37:0] exp_q [$];

  legv8_instr_encoder_if #(.ADDR_W(6)) bus ();

  legv8_instr_encoder #(
    .DEPTH(4),
    .ADDR_W(6),
    .BASE_ADDR(6'd0)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .clear(clear),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge unless clear overrides it.
  initial begin
    logic [37:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && !clear && bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_out: got instr 0x%0h addr %0d expected nothing",
                   bus.out_instr, bus.out_addr);
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_instr, bus.out_addr} !== e) begin
            errors++;
            $display("FAIL out_word: got 0x%08h @%0d expected 0x%08h @%0d",
                     bus.out_instr, bus.out_addr, e[37:6], e[5:0]);
          end
        end
      end
    end
  end

  task automatic send(op_t op, logic [4:0] rd, logic [4:0] rn, logic [4:0] rm,
                      logic [18:0] imm, logic legal, logic [31:0] ex_instr,
                      logic [5:0] ex_addr);
    int n = 0;
    bus.in_op = op; bus.in_rd = rd; bus.in_rn = rn; bus.in_rm = rm; bus.in_imm = imm;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected 1");
      bus.in_valid = 1'b0;
      return;
    end
    if (legal) exp_q.push_back({ex_instr, ex_addr});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    clear = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_op = OpAdd; bus.in_rd = '0; bus.in_rn = '0; bus.in_rm = '0;
    bus.in_imm = '0; bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_instr", 64'(bus.out_instr), 64'd0);
    check("rst_out_addr", 64'(bus.out_addr), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // ADD with one-cycle latency
    send(OpAdd, 5'd1, 5'd2, 5'd3, 19'd0, 1'b1, 32'h8B030041, 6'd0);
    check("add_latency", 64'(bus.out_valid), 64'd1);
    check("add_no_err", 64'(bus.err), 64'd0);
    repeat (3) @(posedge clk);

    // LDUR then CBZ, in order
    do_clear();
    send(OpLdur, 5'd5, 5'd6, 5'd0, 19'd8, 1'b1, 32'hF84080C5, 6'd0);
    send(OpCbz, 5'd7, 5'd0, 5'd0, 19'h7FFFE, 1'b1, 32'hB4FFFFC7, 6'd1);
    repeat (3) @(posedge clk);

    // Out-of-range STUR and undefined op: err pulse, nothing pushed
    do_clear();
    send(OpStur, 5'd1, 5'd2, 5'd0, 19'd256, 1'b0, 32'd0, 6'd0);
    check("stur_err", 64'(bus.err), 64'd1);
    check("stur_no_out", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check("stur_err_clr", 64'(bus.err), 64'd0);
    send(OpAdd, 5'd1, 5'd2, 5'd3, 19'd0, 1'b1, 32'h8B030041, 6'd0);
    send(op_t'(3'd7), 5'd1, 5'd1, 5'd1, 19'd0, 1'b0, 32'd0, 6'd0);
    check("undef_err", 64'(bus.err), 64'd1);
    send(OpLdur, 5'd5, 5'd6, 5'd0, 19'h7FF00, 1'b1, 32'hF85000C5, 6'd1);
    repeat (3) @(posedge clk);

    // Backpressure: fill to full, then drain and accept the fifth
    do_clear();
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++)
      send(OpOrr, 5'(i), 5'd0, 5'd9, 19'd0, 1'b1, 32'hAA090000 | 32'(i), 6'(i - 1));
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    check("full_head_addr", 64'(bus.out_addr), 64'd0);
    fork
      send(OpOrr, 5'd5, 5'd0, 5'd9, 19'd0, 1'b1, 32'hAA090005, 6'd4);
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);

    // Asynchronous reset with entries queued
    do_clear();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(OpAdd, 5'd1, 5'd2, 5'd3, 19'd0, 1'b1, 32'h8B030041, 6'(i));
    #3 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_out_addr", 64'(bus.out_addr), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send(OpSub, 5'd4, 5'd5, 5'd6, 19'd0, 1'b1, 32'hCB0600A4, 6'd0);
    repeat (3) @(posedge clk);

    // clear with simultaneous push and pop
    do_clear();
    bus.out_ready = 1'b0;
    send(OpAnd, 5'd1, 5'd2, 5'd3, 19'd0, 1'b1, 32'h8A030041, 6'd0);
    send(OpAnd, 5'd2, 5'd2, 5'd3, 19'd0, 1'b1, 32'h8A030042, 6'd1);
    exp_q.delete();
    clear = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_op = OpAnd; bus.in_rd = 5'd3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    check("clr_empty", 64'(bus.out_valid), 64'd0);
    check("clr_err", 64'(bus.err), 64'd0);
    check("clr_in_ready", 64'(bus.in_ready), 64'd1);
    send(OpAnd, 5'd1, 5'd2, 5'd3, 19'd0, 1'b1, 32'h8A030041, 6'd0);
    repeat (5) @(posedge clk);

    check("drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
